spi_flash_ctrl: RTL
===================

# spi_flash_ctrl

Quad-output flash read controller that sits behind the cache's QSPI-side request interface and drives the external SPI flash pins. On a one-cycle read request it issues a Fast Read Quad Output command (single-line command and address, dummy clocks, quad data) and returns a burst of 32-bit words, one `qspi_dval` pulse per word, for the cache to write into the line being filled. It is the only sequencer of the flash pins; the cache never touches them directly.

## Interface
- `HALF`, 1: SCK half-period in `clk` cycles (≥1); SCK = clk/(2·HALF).
- `BURST_WORDS`, 4: 32-bit words returned per request (≥1).
- `DUMMY_CYCLES`, 8: dummy SCK cycles between address and data.
- `CMD`, 8'h6B: command byte.
- `CS_HIGH`, 4: minimum `clk` cycles CS# stays high between transactions (≥1).

- `clk` in 1: sole clock.
- `rst` in 1: reset, asynchronous, active-high.
- `qspi_addr` in 24: flash byte address, latched when a request is accepted.
- `qspi_read_en` in 1: one-cycle request pulse.
- `qspi_dout` out 32: assembled word, valid only while `qspi_dval`=1.
- `qspi_dval` out 1: one-cycle word-valid strobe.
- `qspi_rready` out 1: controller idle, request will be accepted.
- `spi_sck` out 1: flash clock, mode 0 (idles low).
- `spi_csn` out 1: flash chip select, active low.
- `spi_io_out` out 4: IO0..IO3 output data.
- `spi_io_oe` out 4: per-line output enable.
- `spi_io_in` in 4: IO0..IO3 input data.

## Operation
- Reset (async): `spi_csn`=1, `spi_sck`=0, `spi_io_oe`=0, `spi_io_out`=0, `qspi_dval`=0, `qspi_dout`=0, `qspi_rready`=0, state IDLE. `qspi_rready` rises at the first `clk` edge after `rst` falls. All outputs are registered.
- States: IDLE → CMD → ADDR → DUMMY → DATA → DESEL → IDLE.
- IDLE: `qspi_rready`=1. `qspi_read_en`=1 latches `qspi_addr`, drops `qspi_rready`, asserts `spi_csn`=0, and enters CMD. `qspi_read_en` outside IDLE is ignored. It is not queued.
- CMD: 8 SCK cycles, `CMD` MSB first on IO0, `spi_io_oe`=4'b0001.
- ADDR: 24 SCK cycles, address MSB first on IO0, oe=4'b0001.
- DUMMY: `DUMMY_CYCLES` SCK cycles, oe=4'b0000.
- DATA: 8 SCK cycles per word, oe=0. One nibble is sampled per SCK rising edge, high nibble of each byte first. Bytes are packed little-endian: first byte goes to `qspi_dout[7:0]`, fourth to `[31:24]`. After the 8th nibble of a word, `qspi_dout`/`qspi_dval` update at that same edge. `qspi_dval` is high for exactly one `clk`. After `BURST_WORDS` words, go to DESEL.
- DESEL: `spi_csn`=1, oe=0, for `CS_HIGH` clk cycles, then IDLE.
- SPI bit counter and word counter reset on entry to CMD. There is no wrap handling: the flash auto-increments its address across the burst.

## Timing
- Edge 0 = the `clk` edge sampling `qspi_read_en`=1 in IDLE. At that edge `spi_csn`→0 and IO0 carries CMD bit 7.
- SCK rising edge k (k=0..N−1) occurs at `clk` edge HALF·(2k+1). Falling edge k occurs at HALF·(2k+2). N = 32 + DUMMY_CYCLES + 8·BURST_WORDS.
- Output data changes only on SCK falling edges (or edge 0). Input is sampled at the `clk` edge that drives SCK high.
- The last nibble of word w is sampled at edge HALF·(2·(32+DUMMY_CYCLES+8w+7)+1). `qspi_dval` is high for the following cycle. Defaults give edges 95, 111, 127, 143.
- `spi_csn`→1 at final falling edge HALF·2N (default 144). `qspi_rready`→1 at HALF·2N + CS_HIGH (default 148). A request in that same cycle is accepted.
- `rst` asserted mid-transaction: immediate return to reset values. There is no partial `qspi_dval`. The flash sees CS# rise and aborts.

## Test plan
- Reset: assert `rst` asynchronously between edges. Required: outputs take reset values immediately, and `qspi_rready`=1 one edge after release.
- Default read, addr 24'h012340. Flash model returns bytes 00,11,22,…,FF. Required: IO0 shifts 6B then 012340. `qspi_dval` pulses at edges 95/111/127/143 with words 33221100, 77665544, BBAA9988, FFEEDDCC. CS# rises at 144. `qspi_rready` returns at 148.
- Request ignored: pulse `qspi_read_en` during DATA. Required: no second transaction, and exactly 4 `qspi_dval` pulses.
- Back-to-back: issue a request in the cycle `qspi_rready` returns. Required: CS# was high for exactly 4 clk, and the second transaction matches the first's timing.
- Parameters HALF=3, BURST_WORDS=2, DUMMY_CYCLES=4: required 2 words, with the first `qspi_dval` at edge 3·(2·43+1)=261.
- Mid-burst reset after word 1: required CS#=1 immediately, no further `qspi_dval`, and a clean subsequent read.

Source files
------------

// File: rtl/spi_flash_ctrl.sv
// Quad-output SPI flash read controller: 0x6B-style command, single-line
// address, dummy clocks, then quad data assembled into 32-bit words.
module spi_flash_ctrl #(
  parameter int         HALF         = 1,
  parameter int         BURST_WORDS  = 4,
  parameter int         DUMMY_CYCLES = 8,
  parameter logic [7:0] CMD          = 8'h6B,
  parameter int         CS_HIGH      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] qspi_addr,
  input  logic        qspi_read_en,
  output logic [31:0] qspi_dout,
  output logic        qspi_dval,
  output logic        qspi_rready,
  output logic        spi_sck,
  output logic        spi_csn,
  output logic [3:0]  spi_io_out,
  output logic [3:0]  spi_io_oe,
  input  logic [3:0]  spi_io_in
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DESEL
  } state_t;

  localparam logic [15:0] HALF_LAST = 16'(HALF - 1);
  localparam logic [15:0] CS_LAST   = 16'(CS_HIGH - 1);
  localparam logic [15:0] BW_LAST   = 16'(BURST_WORDS - 1);
  localparam logic [15:0] DUM_LAST  =
    (DUMMY_CYCLES > 0) ? 16'(DUMMY_CYCLES - 1) : 16'd0;

  state_t      state_q;
  logic [15:0] div_q;
  logic [15:0] cnt_q;
  logic [15:0] word_q;
  logic [31:0] sh_q;
  logic [31:0] acc_q;
  logic        sck_q;
  logic        csn_q;
  logic [3:0]  io_q;
  logic [3:0]  oe_q;
  logic [31:0] dout_q;
  logic        dval_q;
  logic        rdy_q;

  logic        tick_d;
  logic        rise_d;
  logic        fall_d;
  logic        start_d;
  logic        active_d;
  logic [4:0]  nib_d;
  logic [31:0] acc_d;

  always_comb begin
    tick_d   = (div_q == HALF_LAST);
    rise_d   = tick_d & ~sck_q;
    fall_d   = tick_d & sck_q;
    active_d = (state_q == S_CMD) || (state_q == S_ADDR) ||
               (state_q == S_DUMMY) || (state_q == S_DATA);
    // the last CS-high cycle doubles as idle so back-to-back keeps CS_HIGH
    start_d  = qspi_read_en &&
               ((state_q == S_IDLE) ||
                ((state_q == S_DESEL) && (cnt_q == CS_LAST)));
    nib_d    = {cnt_q[2:1], ~cnt_q[0], 2'b00};
    acc_d    = acc_q;
    acc_d[nib_d +: 4] = spi_io_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      sh_q    <= '0;
      acc_q   <= '0;
      sck_q   <= 1'b0;
      csn_q   <= 1'b1;
      io_q    <= '0;
      oe_q    <= '0;
      dout_q  <= '0;
      dval_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      dval_q <= 1'b0;
      if (start_d) begin
        state_q <= S_CMD;
        rdy_q   <= 1'b0;
        csn_q   <= 1'b0;
        sck_q   <= 1'b0;
        div_q   <= '0;
        cnt_q   <= '0;
        word_q  <= '0;
        sh_q    <= {CMD, qspi_addr};
        io_q    <= {3'b000, CMD[7]};
        oe_q    <= 4'b0001;
      end else begin
        if (active_d) begin
          if (tick_d) begin
            div_q <= '0;
            sck_q <= ~sck_q;
          end else begin
            div_q <= div_q + 16'd1;
          end
        end
        unique case (state_q)
          S_IDLE: rdy_q <= 1'b1;
          S_CMD: begin
            if (fall_d) begin
              io_q <= {3'b000, sh_q[30]};
              sh_q <= sh_q << 1;
              if (cnt_q == 16'd7) begin
                state_q <= S_ADDR;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_q + 16'd1;
              end
            end
          end
          S_ADDR: begin
            if (fall_d) begin
              if (cnt_q == 16'd23) begin
                state_q <= (DUMMY_CYCLES == 0) ? S_DATA : S_DUMMY;
                cnt_q   <= '0;
                io_q    <= '0;
                oe_q    <= '0;
              end else begin
                io_q  <= {3'b000, sh_q[30]};
                sh_q  <= sh_q << 1;
                cnt_q <= cnt_q + 16'd1;
              end
            end
          end
          S_DUMMY: begin
            if (fall_d) begin
              if (cnt_q == DUM_LAST) begin
                state_q <= S_DATA;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_q + 16'd1;
              end
            end
          end
          S_DATA: begin
            if (rise_d) begin
              acc_q <= acc_d;
              if (cnt_q == 16'd7) begin
                dout_q <= acc_d;
                dval_q <= 1'b1;
              end
            end
            if (fall_d) begin
              if (cnt_q == 16'd7) begin
                cnt_q <= '0;
                if (word_q == BW_LAST) begin
                  state_q <= S_DESEL;
                  csn_q   <= 1'b1;
                end else begin
                  word_q <= word_q + 16'd1;
                end
              end else begin
                cnt_q <= cnt_q + 16'd1;
              end
            end
          end
          S_DESEL: begin
            if (cnt_q == CS_LAST) begin
              state_q <= S_IDLE;
              rdy_q   <= 1'b1;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign qspi_dout   = dout_q;
  assign qspi_dval   = dval_q;
  assign qspi_rready = rdy_q;
  assign spi_sck     = sck_q;
  assign spi_csn     = csn_q;
  assign spi_io_out  = io_q;
  assign spi_io_oe   = oe_q;

endmodule
